// File: rtl/ff_response_checker.sv
// ff_response_checker: replays a stimulus run against a golden D/JK/T model
// and scores the registered response of an external flip-flop under test.
// The response to vector k-1 is visible on dut_q one edge after it was
// applied, so the compare at step k targets the prediction made at step k-1.
module ff_response_checker #(
  parameter int NUM_STEPS = 8,
  parameter int CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             dut_q,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [4:0]       first_fail_step,
  output logic             first_fail_valid
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0]       MODE_D    = 2'd0;
  localparam logic [1:0]       MODE_JK   = 2'd1;
  localparam logic [1:0]       MODE_T    = 2'd2;
  localparam logic [1:0]       MODE_RSV  = 2'd3;
  localparam logic [4:0]       LAST_STEP = 5'(NUM_STEPS);
  localparam logic [CNT_W-1:0] ERR_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ERR_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ERR_ZERO  = {CNT_W{1'b0}};

  state_t           state_q, state_d;
  logic [4:0]       step_q, step_d;
  logic             g_q, g_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [4:0]       ffs_q, ffs_d;
  logic             ffv_q, ffv_d;
  logic             pass_q, pass_d;

  // Next golden state for the selected flip-flop type; reserved mode holds.
  function automatic logic golden_next(input logic [1:0] m, input logic g,
                                       input logic a, input logic b);
    logic r;
    r = g;
    case (m)
      MODE_D:  r = a;
      MODE_JK: begin
        case ({a, b})
          2'b00:   r = g;
          2'b01:   r = 1'b0;
          2'b10:   r = 1'b1;
          default: r = ~g;
        endcase
      end
      MODE_T:  r = g ^ a;
      default: r = g;
    endcase
    return r;
  endfunction

  // Next-state logic: run control, golden model, mismatch scoring.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    g_d     = g_q;
    mode_d  = mode_q;
    err_d   = err_q;
    ffs_d   = ffs_q;
    ffv_d   = ffv_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mode_d = mode;
          err_d  = ERR_ZERO;
          ffs_d  = 5'd0;
          ffv_d  = 1'b0;
          pass_d = 1'b0;
          g_d    = 1'b0;
          step_d = 5'd0;
          if (mode == MODE_RSV) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        // Step 0 has no response to score yet.
        if ((step_q != 5'd0) && (dut_q != g_q)) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + ERR_ONE;
          end else begin
            err_d = err_q;
          end
          if (!ffv_q) begin
            ffs_d = step_q - 5'd1;
            ffv_d = 1'b1;
          end else begin
            ffs_d = ffs_q;
          end
        end else begin
          err_d = err_q;
        end
        step_d = step_q + 5'd1;
        if (step_q == LAST_STEP) begin
          state_d = ST_DONE;
          pass_d  = (err_d == ERR_ZERO);
        end else begin
          g_d = golden_next(mode_q, g_q, in_a, in_b);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over start.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      step_q  <= 5'd0;
      g_q     <= 1'b0;
      mode_q  <= 2'd0;
      err_q   <= ERR_ZERO;
      ffs_q   <= 5'd0;
      ffv_q   <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      g_q     <= g_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      ffs_q   <= ffs_d;
      ffv_q   <= ffv_d;
      pass_q  <= pass_d;
    end
  end

  assign busy             = (state_q == ST_RUN);
  assign done             = (state_q == ST_DONE);
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_step  = ffs_q;
  assign first_fail_valid = ffv_q;

endmodule

// File: doc/ff_response_checker.md
FF_RESPONSE_CHECKER -- requirements
Module: ff_response_checker

Interface
REQ-001 SHALL have parameter NUM_STEPS, default 8, meaning number of stimulus vectors per run (1..31).
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the mismatch counter.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a run.
REQ-006 SHALL have port mode  input  2  golden model select: 0=D, 1=JK, 2=T, 3=reserved.
REQ-007 SHALL have port in_a  input  1  stimulus applied to the DUT this cycle (d, j or t).
REQ-008 SHALL have port in_b  input  1  second stimulus (k); ignored unless mode=JK.
REQ-009 SHALL have port dut_q  input  1  registered output of the flip-flop under test.
REQ-010 SHALL have port busy  output  1  high while in RUN.
REQ-011 SHALL have port done  output  1  high while in DONE.
REQ-012 SHALL have port pass  output  1  valid when done=1: 1 iff err_count=0 and mode was legal.
REQ-013 SHALL have port err_count  output  CNT_W  number of mismatches in the current or last run.
REQ-014 SHALL have port first_fail_step  output  5  index of the first failing vector.
REQ-015 SHALL have port first_fail_valid  output  1  high once any mismatch is recorded.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DONE.
REQ-017 SHALL latch mode on the start edge and ignore mode changes until the next start.
REQ-018 SHALL handle start as follows:
- IDLE or DONE, legal mode: clear err_count, first_fail_*, golden register g=0 and step=0; enter RUN.
- Latched mode=3: enter DONE directly with pass=0 and err_count=0.
REQ-019 SHALL ignore start while in RUN.
REQ-020 SHALL do the following on each RUN edge with step=k:
- If k>0, compare dut_q with g (the prediction for vector k-1).
- If k<NUM_STEPS, update g from in_a/in_b.
- Increment step.
REQ-021 SHALL update the golden model g as follows:
- D: g<=in_a.
- JK: 00 hold, 01 g<=0, 10 g<=1, 11 g<=~g.
- T: g<=g^in_a.
REQ-022 SHALL, on a mismatch at step k, increment err_count, saturating at 2^CNT_W-1 with no wrap.
REQ-023 SHALL, on the first mismatch of a run, set first_fail_step=k-1 and first_fail_valid=1, and hold both unchanged for later mismatches.
REQ-024 SHALL perform the compare at step k=NUM_STEPS, skip the g update, and enter DONE on that same edge; RUN therefore lasts exactly NUM_STEPS+1 cycles.
REQ-025 SHALL hold pass, err_count and first_fail_* stable in DONE until the next start or RESET.
REQ-026 SHALL derive busy and done combinationally from state, mutually exclusive.
REQ-027 SHALL expect the DUT to be reset alongside the checker, so that dut_q=0 before vector 0.

Reset
REQ-028 SHALL, while RESET=1 at a rising edge, force state=IDLE, step=0, g=0, err_count=0, first_fail_step=0, first_fail_valid=0, pass=0 and latched mode=0.
REQ-029 SHALL let RESET take priority over start and abort an in-progress RUN with no result retained.
REQ-030 SHALL reach IDLE on the first edge after RESET deasserts, with busy=0 and done=0.

Verification
REQ-031 SHALL cover: JK mode, vectors jk=00,01,10,00,11,00,10,11 into a correct JK FF (q sequence 0,0,1,1,0,0,1,0) -> done after 9 RUN cycles, pass=1, err_count=0.
REQ-032 SHALL cover: T mode, t=0,0,1,1,0,1,0,1 with dut_q forced to the correct sequence except an inverted response to vector 3 -> err_count=1, first_fail_step=3, pass=0.
REQ-033 SHALL cover: D mode, dut_q stuck at 1, d=0 for all 8 vectors -> err_count=8, first_fail_step=0; with CNT_W=2 -> err_count=3 (saturated).
REQ-034 SHALL cover: start with mode=3 -> done=1 on the next cycle, pass=0, busy never asserted.
REQ-035 SHALL cover: RESET pulsed at RUN step 4 -> IDLE next cycle, all outputs 0; a new start then yields a full 9-cycle run.
REQ-036 SHALL cover: start pulsed again mid-RUN, and mode changed mid-RUN -> no effect on step count, golden model or result.
